// File: rtl/cpu_parametrizada.sv
// cpu_parametrizada: parametrised accumulator CPU with program load port, start/halt control and JNZ
//
// Ports:
//   clock      rising-edge system clock
//   reset      asynchronous active-high reset; the instruction memory keeps its contents
//   start      begin execution at address 0 (honoured in IDLE/HALT only)
//   prog_we    instruction memory write strobe (honoured in IDLE/HALT only)
//   prog_addr  instruction memory write address
//   prog_data  instruction word {opcode[2:0], imm[WIDTH-1:0]}
//   regX       register X
//   regY       register Y, the ALU result
//   regZ       register Z, the value Y held before its last write
//   pc         program counter
//   carry      carry of ADD / borrow of SUB
//   zero       set when the last value written to Y was zero
//   rco        one-cycle pulse after a fetch wraps the PC from its top address to 0
//   busy       high while fetching or executing
//   halted     high after a HLT until the next start
module cpu_parametrizada #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WIDTH+2:0]  prog_data,
    output logic [WIDTH-1:0]  regX,
    output logic [WIDTH-1:0]  regY,
    output logic [WIDTH-1:0]  regZ,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic              zero,
    output logic              rco,
    output logic              busy,
    output logic              halted
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDX  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_CLRY = 3'd4;
    localparam logic [2:0] OP_MOVY = 3'd5;
    localparam logic [2:0] OP_JNZ  = 3'd6;
    localparam logic [2:0] OP_HLT  = 3'd7;
    // jump target takes the low bits shared by the immediate and the PC
    localparam int JW = (ADDR_W < WIDTH) ? ADDR_W : WIDTH;

    state_t            state_q, state_d;
    logic [WIDTH+2:0]  mem [2**ADDR_W];
    logic [WIDTH+2:0]  ir_q, ir_d;
    logic [WIDTH-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic [ADDR_W-1:0] pc_q, pc_d, jmp;
    logic              carry_q, carry_d, zero_q, zero_d, rco_q, rco_d;
    logic [2:0]        op;
    logic [WIDTH-1:0]  imm;
    logic [WIDTH:0]    sum, diff;
    logic              ctl_idle, y_we;

    assign op       = ir_q[WIDTH+2:WIDTH];
    assign imm      = ir_q[WIDTH-1:0];
    // the extra top bit is the carry for ADD and the borrow for SUB
    assign sum      = {1'b0, y_q} + {1'b0, x_q};
    assign diff     = {1'b0, y_q} - {1'b0, x_q};
    assign ctl_idle = (state_q == IDLE) || (state_q == HALT);

    always_comb begin
        jmp         = '0;
        jmp[JW-1:0] = imm[JW-1:0];
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        rco_d   = 1'b0;
        y_we    = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = mem[pc_q];
                pc_d    = pc_q + ADDR_W'(1);
                rco_d   = &pc_q;
                state_d = EXEC;
            end
            default: begin
                state_d = FETCH;
                case (op)
                    OP_LDX:  x_d = imm;
                    OP_ADD:  begin y_d = sum[WIDTH-1:0];  carry_d = sum[WIDTH];  y_we = 1'b1; end
                    OP_SUB:  begin y_d = diff[WIDTH-1:0]; carry_d = diff[WIDTH]; y_we = 1'b1; end
                    OP_CLRY: begin y_d = '0; carry_d = 1'b0; y_we = 1'b1; end
                    OP_MOVY: begin y_d = x_q; y_we = 1'b1; end
                    OP_JNZ:  pc_d = (y_q != '0) ? jmp : pc_q;
                    OP_HLT:  state_d = HALT;
                    OP_NOP:  ;
                    default: ;
                endcase
                if (y_we) begin
                    z_d    = y_q;
                    zero_d = (y_d == '0);
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            rco_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            rco_q   <= rco_d;
        end
    end

    // the program survives reset, so the memory has no reset branch
    always_ff @(posedge clock) begin
        if (prog_we && ctl_idle) mem[prog_addr] <= prog_data;
    end

    assign regX   = x_q;
    assign regY   = y_q;
    assign regZ   = z_q;
    assign pc     = pc_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign rco    = rco_q;
    assign busy   = (state_q == FETCH) || (state_q == EXEC);
    assign halted = (state_q == HALT);
endmodule

// File: tb/tb_cpu_parametrizada.sv
// tb_cpu_parametrizada: scoreboard bench for cpu_parametrizada at WIDTH=4/ADDR_W=4 and WIDTH=8/ADDR_W=3
module tb_cpu_parametrizada;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       start4 = 1'b0, we4 = 1'b0;
    logic [3:0] pa4 = '0;
    logic [6:0] pd4 = '0;
    logic [3:0] x4, y4, z4, pc4;
    logic       c4, zr4, rco4, busy4, halt4;

    logic        start8 = 1'b0, we8 = 1'b0;
    logic [2:0]  pa8 = '0;
    logic [10:0] pd8 = '0;
    logic [7:0]  x8, y8, z8;
    logic [2:0]  pc8;
    logic        c8, zr8, rco8, busy8, halt8;

    cpu_parametrizada #(.WIDTH(4), .ADDR_W(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .prog_we(we4), .prog_addr(pa4), .prog_data(pd4),
        .regX(x4), .regY(y4), .regZ(z4), .pc(pc4), .carry(c4), .zero(zr4), .rco(rco4),
        .busy(busy4), .halted(halt4));

    cpu_parametrizada #(.WIDTH(8), .ADDR_W(3)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .prog_we(we8), .prog_addr(pa8), .prog_data(pd8),
        .regX(x8), .regY(y8), .regZ(z8), .pc(pc8), .carry(c8), .zero(zr8), .rco(rco8),
        .busy(busy8), .halted(halt8));

    typedef struct {int x; int y; int z; int pc; int c; int zr; int cyc; int rco;} exp_t;

    exp_t sb4[$];
    exp_t sb8[$];
    int   checks = 0;
    int   errors = 0;
    int   prog_op[16];
    int   prog_imm[16];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_rec(string t, exp_t e, logic [31:0] x, logic [31:0] y, logic [31:0] z,
                           logic [31:0] p, logic [31:0] c, logic [31:0] zr, int cy, int rc);
        chk({t, ".x"}, x, e.x);
        chk({t, ".y"}, y, e.y);
        chk({t, ".z"}, z, e.z);
        chk({t, ".pc"}, p, e.pc);
        chk({t, ".carry"}, c, e.c);
        chk({t, ".zero"}, zr, e.zr);
        chk({t, ".cycles"}, cy, e.cyc);
        chk({t, ".rco"}, rc, e.rco);
    endtask

    // Instruction-level interpreter: executes prog_op/prog_imm from address 0 with all registers cleared
    function automatic exp_t model(int w, int aw, output bit ok);
        exp_t e;
        int   mask  = (1 << w) - 1;
        int   depth = 1 << aw;
        int   p     = 0;
        int   op, imm, s;
        e  = '{default: 0};
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            op  = prog_op[p];
            imm = prog_imm[p];
            if (p == depth - 1) e.rco++;
            p = (p + 1) % depth;
            e.cyc += 2;
            case (op)
                1: e.x = imm;
                2: begin s = e.y + e.x; e.z = e.y; e.c = int'(s > mask); e.y = s & mask; e.zr = int'(e.y == 0); end
                3: begin e.z = e.y; e.c = int'(e.y < e.x); e.y = (e.y - e.x) & mask; e.zr = int'(e.y == 0); end
                4: begin e.z = e.y; e.y = 0; e.c = 0; e.zr = 1; end
                5: begin e.z = e.y; e.y = e.x; e.zr = int'(e.y == 0); end
                6: if (e.y != 0) p = imm % depth;
                7: ok = 1'b1;
                default: ;
            endcase
        end
        e.pc = p;
        return e;
    endfunction

    int   cyc4 = 0, rn4 = 0, cyc8 = 0, rn8 = 0;
    logic pb4 = 1'b0, ph4 = 1'b0, pb8 = 1'b0, ph8 = 1'b0;

    always @(negedge clock) begin
        if (busy4 && !pb4) begin cyc4 = 0; rn4 = 0; end
        if (busy4) begin cyc4++; if (rco4) rn4++; end
        if (halt4 && !ph4) begin
            if (sb4.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb4 halt with empty scoreboard");
            end else begin
                exp_t e;
                e = sb4.pop_front();
                cmp_rec("w4", e, 32'(x4), 32'(y4), 32'(z4), 32'(pc4), 32'(c4), 32'(zr4), cyc4, rn4);
            end
        end
        pb4 = busy4;
        ph4 = halt4;
    end

    always @(negedge clock) begin
        if (busy8 && !pb8) begin cyc8 = 0; rn8 = 0; end
        if (busy8) begin cyc8++; if (rco8) rn8++; end
        if (halt8 && !ph8) begin
            if (sb8.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb8 halt with empty scoreboard");
            end else begin
                exp_t e;
                e = sb8.pop_front();
                cmp_rec("w8", e, 32'(x8), 32'(y8), 32'(z8), 32'(pc8), 32'(c8), 32'(zr8), cyc8, rn8);
            end
        end
        pb8 = busy8;
        ph8 = halt8;
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load4(int a, int op, int imm);
        @(negedge clock);
        we4 = 1'b1;
        pa4 = a[3:0];
        pd4 = {op[2:0], imm[3:0]};
        @(negedge clock);
        we4 = 1'b0;
    endtask

    task automatic load8(int a, int op, int imm);
        @(negedge clock);
        we8 = 1'b1;
        pa8 = a[2:0];
        pd8 = {op[2:0], imm[7:0]};
        @(negedge clock);
        we8 = 1'b0;
    endtask

    task automatic run4(exp_t e, bit mid_start);
        int n = 0;
        sb4.push_back(e);
        @(negedge clock) start4 = 1'b1;
        @(negedge clock) start4 = 1'b0;
        if (mid_start) begin
            repeat (3) @(negedge clock);
            start4 = 1'b1;
            @(negedge clock);
            start4 = 1'b0;
        end
        while (!halt4 && n < 2000) begin @(negedge clock); n++; end
        if (!halt4) begin
            checks++; errors++;
            $display("FAIL run4 timeout halted=%0d required 1", halt4);
            sb4.delete();
        end
        @(negedge clock);
    endtask

    task automatic run8(exp_t e);
        int n = 0;
        sb8.push_back(e);
        @(negedge clock) start8 = 1'b1;
        @(negedge clock) start8 = 1'b0;
        while (!halt8 && n < 2000) begin @(negedge clock); n++; end
        if (!halt8) begin
            checks++; errors++;
            $display("FAIL run8 timeout halted=%0d required 1", halt8);
            sb8.delete();
        end
        @(negedge clock);
    endtask

    task automatic chk_zero4(string t);
        chk({t, ".x"}, 32'(x4), 0);
        chk({t, ".y"}, 32'(y4), 0);
        chk({t, ".z"}, 32'(z4), 0);
        chk({t, ".pc"}, 32'(pc4), 0);
        chk({t, ".carry"}, 32'(c4), 0);
        chk({t, ".zero"}, 32'(zr4), 0);
        chk({t, ".rco"}, 32'(rco4), 0);
        chk({t, ".busy"}, 32'(busy4), 0);
        chk({t, ".halted"}, 32'(halt4), 0);
    endtask

    initial begin
        exp_t e;
        bit   ok;
        int   rc;
        do_reset();
        chk_zero4("reset4");
        chk("reset8.y", 32'(y8), 0);
        chk("reset8.busy", 32'(busy8), 0);

        load4(0, 1, 3); load4(1, 2, 0); load4(2, 2, 0); load4(3, 7, 0);
        run4('{x: 3, y: 6, z: 3, pc: 4, c: 0, zr: 0, cyc: 8, rco: 0}, 1'b0);

        do_reset();
        load4(0, 1, 5); load4(1, 4, 0); load4(2, 3, 0); load4(3, 7, 0);
        run4('{x: 5, y: 11, z: 0, pc: 4, c: 1, zr: 0, cyc: 8, rco: 0}, 1'b0);

        do_reset();
        load4(0, 1, 3); load4(1, 5, 0); load4(2, 1, 1); load4(3, 3, 0); load4(4, 6, 3); load4(5, 7, 0);
        run4('{x: 1, y: 0, z: 1, pc: 6, c: 0, zr: 1, cyc: 20, rco: 0}, 1'b1);

        do_reset();
        for (int a = 0; a < 16; a++) load4(a, 0, 0);
        @(negedge clock) start4 = 1'b1;
        @(negedge clock) start4 = 1'b0;
        rc = 0;
        for (int i = 0; i < 64; i++) begin
            if (rco4) begin
                rc++;
                chk("nop.rco_pc", 32'(pc4), 0);
            end
            @(negedge clock);
        end
        chk("nop.rco_count", rc, 2);
        chk("nop.busy", 32'(busy4), 1);
        chk("nop.halted", 32'(halt4), 0);

        do_reset();
        load4(0, 1, 3); load4(1, 2, 0); load4(2, 2, 0); load4(3, 7, 0);
        @(negedge clock) start4 = 1'b1;
        @(negedge clock) start4 = 1'b0;
        we4 = 1'b1; pa4 = 4'd0; pd4 = 7'b1110000;
        @(posedge clock);
        #2 reset = 1'b1;
        we4 = 1'b0;
        #1 chk_zero4("midreset");
        @(negedge clock) reset = 1'b0;
        run4('{x: 3, y: 6, z: 3, pc: 4, c: 0, zr: 0, cyc: 8, rco: 0}, 1'b0);

        for (int r = 0; r < 20; r++) begin
            ok = 1'b0;
            for (int t = 0; t < 100 && !ok; t++) begin
                for (int a = 0; a < 16; a++) begin
                    prog_op[a]  = int'($urandom_range(0, 7));
                    prog_imm[a] = int'($urandom_range(0, 15));
                end
                e = model(4, 4, ok);
            end
            if (ok) begin
                do_reset();
                for (int a = 0; a < 16; a++) load4(a, prog_op[a], prog_imm[a]);
                run4(e, 1'b0);
            end
        end

        do_reset();
        load8(0, 1, 200); load8(1, 5, 0); load8(2, 2, 0); load8(3, 7, 0);
        run8('{x: 200, y: 144, z: 200, pc: 4, c: 1, zr: 0, cyc: 8, rco: 0});

        for (int r = 0; r < 12; r++) begin
            ok = 1'b0;
            for (int t = 0; t < 100 && !ok; t++) begin
                for (int a = 0; a < 8; a++) begin
                    prog_op[a]  = int'($urandom_range(0, 7));
                    prog_imm[a] = int'($urandom_range(0, 255));
                end
                e = model(8, 3, ok);
            end
            if (ok) begin
                do_reset();
                for (int a = 0; a < 8; a++) load8(a, prog_op[a], prog_imm[a]);
                run8(e);
            end
        end

        chk("sb4.leftover", sb4.size(), 0);
        chk("sb8.leftover", sb8.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
